// File: rtl/ff_monitor.sv
// ----------------------------------------------------------------------------
// ff_monitor
//
// Watches the direct and inverted outputs of five flip-flops
// (T, JK, D, DL and RS) over a fixed run window. If a checked pair is not
// complementary, the block records the first failing set of pairs. While the
// window runs, it also counts rising edges on the T and JK direct outputs.
//
// Parameters
//   WIN      run-window length in clock cycles (2..255)
//   CW       width of the T / JK edge counters
//
// Ports
//   C        clock, all state changes on the rising edge
//   R        asynchronous active-low reset
//   EN       start request, honoured only in IDLE
//   CLR      synchronous clear back to IDLE
//   CHK      per-pair check enable          {T,JK,D,DL,RS}
//   QV       flip-flop direct outputs       {TQ,JKQ,DQ,DLQ,RSQ}
//   NQV      flip-flop inverted outputs     {TnQ,JKnQ,DnQ,DLnQ,RSnQ}
//   BUSY     high while arming or running a window
//   DONE     window completed without a violation (sticky)
//   ERR      complementarity violation captured (sticky)
//   ERR_MASK pairs violating at the first error
//   ERR_IDX  lowest violating pair index (0=RS .. 4=T)
//   T_CNT    rising edges of TQ seen during RUN (saturating)
//   JK_CNT   rising edges of JKQ seen during RUN (saturating)
// ----------------------------------------------------------------------------
module ff_monitor #(
   parameter int WIN = 64,
   parameter int CW  = 8
) (
   input  logic          C,
   input  logic          R,
   input  logic          EN,
   input  logic          CLR,
   input  logic [4:0]    CHK,
   input  logic [4:0]    QV,
   input  logic [4:0]    NQV,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic [4:0]    ERR_MASK,
   output logic [2:0]    ERR_IDX,
   output logic [CW-1:0] T_CNT,
   output logic [CW-1:0] JK_CNT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [7:0]    WIN_LAST = 8'(WIN - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t     state;
   logic [4:0] qs;
   logic [4:0] nqs;
   logic [4:0] qp;
   logic [7:0] wcnt;
   logic       rel_p0;
   logic       rel_p1;
   logic [4:0] v;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [2:0] lowest_idx(input logic [4:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (&c) ? c : c + CNT_ONE;
   endfunction

   // A pair is in violation when its sampled Q and nQ are equal.
   assign v = CHK & ~(qs ^ nqs);

   // Reset release synchroniser: assertion is immediate, release takes two
   // clean edges, so EN is never acted on in the partial cycle after R rises.
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         rel_p0 <= 1'b0;
         rel_p1 <= 1'b0;
      end else begin
         rel_p0 <= 1'b1;
         rel_p1 <= rel_p0;
      end
   end

   // Sample stage, control FSM and registered outputs.
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state    <= S_IDLE;
         qs       <= '0;
         nqs      <= '0;
         qp       <= '0;
         wcnt     <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         ERR_MASK <= '0;
         ERR_IDX  <= '0;
         T_CNT    <= '0;
         JK_CNT   <= '0;
      end else begin
         qs  <= QV;
         nqs <= NQV;
         qp  <= qs;

         if (CLR) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_MASK <= '0;
            ERR_IDX  <= '0;
            T_CNT    <= '0;
            JK_CNT   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (EN && rel_p1) begin
                     state <= S_ARM;
                     BUSY  <= 1'b1;
                  end
               end

               S_ARM: begin
                  state <= S_RUN;
                  wcnt  <= '0;
               end

               S_RUN: begin
                  if (qs[4] && !qp[4]) T_CNT  <= sat_inc(T_CNT);
                  if (qs[3] && !qp[3]) JK_CNT <= sat_inc(JK_CNT);

                  // A violation on the last window cycle still wins over DONE.
                  if (|v) begin
                     state    <= S_FAIL;
                     BUSY     <= 1'b0;
                     ERR      <= 1'b1;
                     ERR_MASK <= v;
                     ERR_IDX  <= lowest_idx(v);
                  end else if (wcnt == WIN_LAST) begin
                     state <= S_DONE;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end else begin
                     wcnt <= wcnt + 8'd1;
                  end
               end

               S_DONE, S_FAIL: begin
                  state <= state;
               end

               default: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ff_monitor.sv
module tb_ff_monitor;

   localparam int WIN  = 64;
   localparam int NCYC = 76;

   logic       C = 1'b0;
   logic       R = 1'b0;
   logic       EN = 1'b0;
   logic       CLR = 1'b0;
   logic [4:0] CHK = 5'h00;
   logic [4:0] QV = 5'h00;
   logic [4:0] NQV = 5'h1f;

   logic       busy8, done8, err8, busy4, done4, err4;
   logic [4:0] mask8, mask4;
   logic [2:0] idx8, idx4;
   logic [7:0] t8, jk8;
   logic [3:0] t4, jk4;

   ff_monitor #(.WIN(WIN), .CW(8)) dut8 (
      .C(C), .R(R), .EN(EN), .CLR(CLR), .CHK(CHK), .QV(QV), .NQV(NQV),
      .BUSY(busy8), .DONE(done8), .ERR(err8), .ERR_MASK(mask8),
      .ERR_IDX(idx8), .T_CNT(t8), .JK_CNT(jk8)
   );

   ff_monitor #(.WIN(WIN), .CW(4)) dut4 (
      .C(C), .R(R), .EN(EN), .CLR(CLR), .CHK(CHK), .QV(QV), .NQV(NQV),
      .BUSY(busy4), .DONE(done4), .ERR(err4), .ERR_MASK(mask4),
      .ERR_IDX(idx4), .T_CNT(t4), .JK_CNT(jk4)
   );

   always #5 C = ~C;

   int n_chk = 0;
   int n_fail = 0;

   // Stimulus tables: entry c is what sits on the inputs before edge c.
   logic [4:0] a_qv  [0:NCYC-1];
   logic [4:0] a_nqv [0:NCYC-1];
   logic [4:0] a_chk [0:NCYC-1];

   // Expected results from the reference model.
   logic       exp_fail;
   logic [4:0] exp_mask;
   int         exp_idx, exp_t, exp_jk, exp_jend;

   // Observations gathered while driving.
   int busy_cnt, first_err, first_done;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Fill the tables for one scenario. EN is pulsed before edge 0.
   task automatic build_stim(input int kind);
      logic [31:0] r;
      logic [31:0] m;
      int j0;
      j0 = $urandom_range(0, 62);
      for (int c = 0; c < NCYC; c++) begin
         r = $urandom;
         a_qv[c]  = r[4:0];
         a_nqv[c] = ~r[4:0];
         a_chk[c] = 5'h1f;
         case (kind)
            1: if (c == 1 + j0) a_nqv[c][2] = a_qv[c][2];
            2: begin
               a_chk[c] = 5'b11011;
               if (c == 1 + j0) a_nqv[c][2] = a_qv[c][2];
            end
            3: begin
               a_qv[c][4]  = c[0];
               a_nqv[c][4] = ~c[0];
            end
            4: if (c == WIN) begin
               a_nqv[c][0] = a_qv[c][0];
               a_nqv[c][4] = a_qv[c][4];
            end
            5: begin
               m = $urandom;
               if ($urandom_range(0, 3) == 0) a_chk[c] = m[9:5];
               if ($urandom_range(0, 39) == 0) a_nqv[c] = a_nqv[c] ^ m[4:0];
            end
            6: begin
               m = $urandom;
               a_chk[c] = 5'h00;
               a_nqv[c] = a_nqv[c] ^ m[4:0];
            end
            default: ;
         endcase
      end
   endtask

   // Reference model: walk the window one run cycle at a time from the
   // sampled-input history, stopping at the first violation.
   task automatic model_window();
      logic [4:0] v;
      exp_fail = 1'b0;
      exp_mask = 5'h00;
      exp_idx  = 0;
      exp_t    = 0;
      exp_jk   = 0;
      exp_jend = WIN - 1;
      for (int j = 0; j < WIN; j++) begin
         if (a_qv[1+j][4] && !a_qv[j][4]) exp_t++;
         if (a_qv[1+j][3] && !a_qv[j][3]) exp_jk++;
         v = a_chk[2+j] & ~(a_qv[1+j] ^ a_nqv[1+j]);
         if (v != 5'h00) begin
            exp_fail = 1'b1;
            exp_mask = v;
            exp_jend = j;
            for (int b = 4; b >= 0; b--) if (v[b]) exp_idx = b;
            break;
         end
      end
   endtask

   // Apply table entries lo..hi, one per clock, sampling 1 time unit after
   // each edge. EN is raised on entry 0 and again late to prove it is ignored.
   task automatic drive_cycles(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) begin
         EN  = (c == 0) || (c >= 70);
         QV  = a_qv[c];
         NQV = a_nqv[c];
         CHK = a_chk[c];
         @(posedge C);
         #1;
         if (busy8) busy_cnt++;
         if (err8 && first_err < 0) first_err = c;
         if (done8 && first_done < 0) first_done = c;
      end
      EN = 1'b0;
   endtask

   task automatic pulse_clr();
      CLR = 1'b1;
      @(posedge C);
      #1;
      CLR = 1'b0;
      busy_cnt   = 0;
      first_err  = -1;
      first_done = -1;
   endtask

   task automatic test_reset();
      R  = 1'b0;
      EN = 1'b1;
      CHK = 5'h1f;
      QV = 5'h15;
      NQV = 5'h15;
      repeat (3) @(posedge C);
      #1;
      EN = 1'b0;
      n_chk++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy8); end
      n_chk++; if (done8 !== 1'b0 || err8 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got done=%b err=%b expected 0 0", done8, err8); end
      n_chk++; if (mask8 !== 5'h00 || idx8 !== 3'd0) begin n_fail++; $display("FAIL reset_err_info: got mask=%b idx=%0d expected 00000 0", mask8, idx8); end
      n_chk++; if (t8 !== 8'd0 || jk8 !== 8'd0) begin n_fail++; $display("FAIL reset_counts: got t=%0d jk=%0d expected 0 0", t8, jk8); end
   endtask

   // EN in the partial cycle right after reset release must not start a run.
   task automatic test_release_sync();
      int seen;
      seen = 0;
      @(negedge C);
      R  = 1'b1;
      EN = 1'b1;
      @(posedge C);
      #1;
      EN = 1'b0;
      if (busy8) seen++;
      for (int i = 0; i < 4; i++) begin
         @(posedge C);
         #1;
         if (busy8) seen++;
      end
      n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL release_en_ignored: got %0d busy cycles expected 0", seen); end
   endtask

   task automatic test_window(input int kind);
      pulse_clr();
      n_chk++; if (busy8 !== 1'b0 || done8 !== 1'b0 || err8 !== 1'b0 || t8 !== 8'd0 || jk8 !== 8'd0)
         begin n_fail++; $display("FAIL clr_state k=%0d: got busy=%b done=%b err=%b t=%0d jk=%0d expected all 0", kind, busy8, done8, err8, t8, jk8); end
      build_stim(kind);
      model_window();
      drive_cycles(0, NCYC - 1);
      n_chk++; if (done8 !== !exp_fail) begin n_fail++; $display("FAIL done k=%0d: got %b expected %b", kind, done8, !exp_fail); end
      n_chk++; if (err8 !== exp_fail) begin n_fail++; $display("FAIL err k=%0d: got %b expected %b", kind, err8, exp_fail); end
      n_chk++; if (mask8 !== exp_mask) begin n_fail++; $display("FAIL err_mask k=%0d: got %b expected %b", kind, mask8, exp_mask); end
      n_chk++; if (idx8 !== 3'(exp_idx)) begin n_fail++; $display("FAIL err_idx k=%0d: got %0d expected %0d", kind, idx8, exp_idx); end
      n_chk++; if (busy_cnt !== exp_jend + 2) begin n_fail++; $display("FAIL busy_cycles k=%0d: got %0d expected %0d", kind, busy_cnt, exp_jend + 2); end
      n_chk++; if (exp_fail && first_err !== exp_jend + 2) begin n_fail++; $display("FAIL err_latency k=%0d: got %0d expected %0d", kind, first_err, exp_jend + 2); end
      n_chk++; if (!exp_fail && first_done !== WIN + 1) begin n_fail++; $display("FAIL done_cycle k=%0d: got %0d expected %0d", kind, first_done, WIN + 1); end
      n_chk++; if (t8 !== 8'((exp_t > 255) ? 255 : exp_t)) begin n_fail++; $display("FAIL t_cnt k=%0d: got %0d expected %0d", kind, t8, exp_t); end
      n_chk++; if (jk8 !== 8'((exp_jk > 255) ? 255 : exp_jk)) begin n_fail++; $display("FAIL jk_cnt k=%0d: got %0d expected %0d", kind, jk8, exp_jk); end
      n_chk++; if (t4 !== 4'((exp_t > 15) ? 15 : exp_t)) begin n_fail++; $display("FAIL t_cnt_cw4 k=%0d: got %0d expected %0d", kind, t4, (exp_t > 15) ? 15 : exp_t); end
      n_chk++; if (jk4 !== 4'((exp_jk > 15) ? 15 : exp_jk)) begin n_fail++; $display("FAIL jk_cnt_cw4 k=%0d: got %0d expected %0d", kind, jk4, (exp_jk > 15) ? 15 : exp_jk); end
      n_chk++; if (done4 !== !exp_fail || err4 !== exp_fail) begin n_fail++; $display("FAIL cw4_flags k=%0d: got done=%b err=%b expected %b %b", kind, done4, err4, !exp_fail, exp_fail); end
      if (kind == 3) begin
         n_chk++; if (t8 !== 8'd32) begin n_fail++; $display("FAIL toggle_t_cnt: got %0d expected 32", t8); end
         n_chk++; if (t4 !== 4'd15) begin n_fail++; $display("FAIL toggle_t_cnt_sat: got %0d expected 15", t4); end
      end
      if (kind == 4) begin
         n_chk++; if (mask8 !== 5'b10001 || idx8 !== 3'd0) begin n_fail++; $display("FAIL final_cycle_err: got mask=%b idx=%0d expected 10001 0", mask8, idx8); end
      end
   endtask

   // CLR during RUN, with EN also high, must return to IDLE and wipe counts.
   task automatic test_clr_mid_run();
      pulse_clr();
      build_stim(3);
      drive_cycles(0, 29);
      CLR = 1'b1;
      EN  = 1'b1;
      @(posedge C);
      #1;
      CLR = 1'b0;
      EN  = 1'b0;
      n_chk++; if (busy8 !== 1'b0 || t8 !== 8'd0 || jk8 !== 8'd0 || done8 !== 1'b0)
         begin n_fail++; $display("FAIL clr_mid_run: got busy=%b t=%0d jk=%0d done=%b expected 0 0 0 0", busy8, t8, jk8, done8); end
      @(posedge C);
      #1;
      n_chk++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL clr_over_en: got busy=%b expected 0", busy8); end
   endtask

   // Asynchronous reset in the middle of a window, then a fresh full window.
   task automatic test_reset_mid_run();
      int seen;
      seen = 0;
      pulse_clr();
      build_stim(3);
      drive_cycles(0, 19);
      #2;
      R = 1'b0;
      #1;
      n_chk++; if (busy8 !== 1'b0 || done8 !== 1'b0 || err8 !== 1'b0 || mask8 !== 5'h00 || idx8 !== 3'd0 || t8 !== 8'd0 || jk8 !== 8'd0)
         begin n_fail++; $display("FAIL async_reset: got busy=%b done=%b err=%b mask=%b idx=%0d t=%0d jk=%0d expected all 0", busy8, done8, err8, mask8, idx8, t8, jk8); end
      @(negedge C);
      R = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge C);
         #1;
         if (busy8) seen++;
      end
      n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL idle_after_reset: got %0d busy cycles expected 0", seen); end
      test_window(0);
   endtask

   initial begin
      test_reset();
      test_release_sync();
      test_window(0);
      test_window(1);
      test_window(2);
      test_window(3);
      test_window(4);
      test_window(5);
      test_window(5);
      test_window(6);
      test_clr_mid_run();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
